// File: rtl/puf_soc_pkg.sv
// PUF SoC shared constants and types.
// Used by the ring-oscillator enable decoder.
package puf_soc_pkg;

  localparam int MUX_LENGTH_DFLT = 16;
  localparam int SEL_W = $clog2(MUX_LENGTH_DFLT);

  typedef logic [SEL_W-1:0]           sel_t;
  typedef logic [MUX_LENGTH_DFLT-1:0] puf_en_t;

  // Reference one-hot for the default configuration.
  function automatic puf_en_t onehot(input sel_t k);
    puf_en_t v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/puf_soc_onehot_dec.sv
// Combinational select-to-one-hot decoder.
// One instance per RO mux.
import puf_soc_pkg::*;

module puf_soc_onehot_dec #(
  parameter int N = MUX_LENGTH_DFLT,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] i_sel,
  output logic [N-1:0] o_onehot
);

  // Select width matches N, so every index maps to a real bit.
  always_comb begin
    o_onehot = N'(1) << i_sel;
  end

endmodule

// File: rtl/puf_soc_ro_decoder.sv
// Ring-oscillator enable decoder: two selects
// become a registered enable vector for the RO array.
import puf_soc_pkg::*;

module puf_soc_ro_decoder #(
  parameter int MUX_LENGTH = MUX_LENGTH_DFLT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_dcod_en,
  input  logic [$clog2(MUX_LENGTH)-1:0] i_sel_mux_0,
  input  logic [$clog2(MUX_LENGTH)-1:0] i_sel_mux_1,
  output logic [MUX_LENGTH-1:0]         o_puf_en
);

  localparam int SW = $clog2(MUX_LENGTH);

  if (MUX_LENGTH < 2 ||
      (MUX_LENGTH & (MUX_LENGTH - 1)) != 0) begin : g_chk
    $error("MUX_LENGTH must be a power of two >= 2");
  end

  logic [MUX_LENGTH-1:0] w_oh_0;
  logic [MUX_LENGTH-1:0] w_oh_1;
  logic [MUX_LENGTH-1:0] r_puf_en;

  puf_soc_onehot_dec #(
    .N (MUX_LENGTH),
    .W (SW)
  ) u_dec_0 (
    .i_sel    (i_sel_mux_0),
    .o_onehot (w_oh_0)
  );

  puf_soc_onehot_dec #(
    .N (MUX_LENGTH),
    .W (SW)
  ) u_dec_1 (
    .i_sel    (i_sel_mux_1),
    .o_onehot (w_oh_1)
  );

  // Register the merged enables; gate all ROs off when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_puf_en <= '0;
    end else if (i_dcod_en) begin
      r_puf_en <= w_oh_0 | w_oh_1;
    end else begin
      r_puf_en <= '0;
    end
  end

  assign o_puf_en = r_puf_en;

`ifndef SYNTHESIS
  a_popcnt: assert property (
    @(posedge clk) disable iff (!rst_n)
    $countones(o_puf_en) <= 2
  );

  a_gated: assert property (
    @(posedge clk) disable iff (!rst_n)
    !i_dcod_en |=> o_puf_en == '0
  );
`endif

endmodule

// File: tb/tb_puf_soc_ro_decoder.sv
// Randomized and directed bench for the RO
// enable decoder against a behavioural model.
module tb_puf_soc_ro_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  s0 = '0;
  logic [3:0]  s1 = '0;
  logic [15:0] puf;

  int n_tot = 0;
  int n_bad = 0;
  int n_odd = 0;

  always #5 clk = ~clk;

  puf_soc_ro_decoder #(
    .MUX_LENGTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_dcod_en   (en),
    .i_sel_mux_0 (s0),
    .i_sel_mux_1 (s1),
    .o_puf_en    (puf)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bit i is on iff enabled and i is one of the selects.
  function automatic logic [15:0] ref_en(
    input bit e, input int a, input int b);
    logic [15:0] v;
    for (int i = 0; i < 16; i++)
      v[i] = e && (i == a || i == b);
    return v;
  endfunction

  task automatic step(input bit e, input int a,
                      input int b, input string tag);
    en = e;
    s0 = 4'(a);
    s1 = 4'(b);
    @(posedge clk);
    #1;
    chk(tag, puf, ref_en(e, a, b));
  endtask

  initial begin
    // Reset held with zero inputs.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", puf, 16'h0000);
    end

    // Release with enable already set.
    rst_n = 1'b1;
    step(1, 3, 9, "single");
    chk("single_k", puf, 16'h0208);

    // Before the edge the old value is still shown.
    en = 1'b1;
    s0 = 4'd5;
    s1 = 4'd5;
    #3;
    chk("latency", puf, 16'h0208);
    @(posedge clk);
    #1;
    chk("equal", puf, 16'h0020);
    chk("equal_par", {15'b0, ^puf}, 16'h0001);

    // Every select pair, one per clock.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        step(1, a, b, "sweep");
        if ($countones(puf) == 1) n_odd++;
      end
    end
    chk("odd_cnt", 16'(n_odd), 16'd16);

    // Enable gating and resume.
    step(1, 0, 15, "gate_on");
    chk("gate_on_k", puf, 16'h8001);
    step(0, $urandom_range(15), $urandom_range(15), "gate_off");
    step(0, 15, 0, "gate_off2");
    step(1, 7, 2, "gate_resume");

    // Boundary selects.
    step(1, 0, 0, "lo_lo");
    chk("lo_lo_k", puf, 16'h0001);
    step(1, 15, 15, "hi_hi");
    chk("hi_hi_k", puf, 16'h8000);

    // Async reset mid-cycle while nonzero.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", puf, 16'h0000);
    en = 1'b1;
    s0 = 4'd4;
    s1 = 4'd11;
    @(posedge clk);
    #1;
    chk("rst_async_hold", puf, 16'h0000);
    rst_n = 1'b1;
    step(1, 4, 11, "rst_resume");

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(3) != 0),
           $urandom_range(15),
           $urandom_range(15), "rand");
    end

    $display("test done: total=%0d bad=%0d",
             n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/puf_soc_ro_decoder.md
Name: puf_soc_ro_decoder

Overview:
Ring-oscillator enable decoder for the PUF SoC.
- Takes two RO-mux select indices and produces a registered enable vector with one bit set per selected oscillator.
- The two selected ROs can then be run and compared.
- Sits between the PUF controller, which supplies the selects and enable, and the RO array, which consumes o_puf_en.

Parameters:
- MUX_LENGTH, 16: number of ring oscillators per mux, which is also the width of o_puf_en. Must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_dcod_en  input  1  decoder enable.
- i_sel_mux_0  input  $clog2(MUX_LENGTH)  RO index for mux 0.
- i_sel_mux_1  input  $clog2(MUX_LENGTH)  RO index for mux 1.
- o_puf_en  output  MUX_LENGTH  registered RO enable vector.

Behaviour:
- Reset: rst_n low clears o_puf_en to all-zeros immediately, independent of clk, and holds it there while rst_n stays low.
- Enabled update: on each rising clk with rst_n high and i_dcod_en=1, o_puf_en <= onehot(i_sel_mux_0) | onehot(i_sel_mux_1).
  - onehot(k) sets bit k only.
- Disabled update: on each rising clk with rst_n high and i_dcod_en=0, o_puf_en <= 0. All oscillators are gated off while disabled.
- Latency: exactly one clock from a select or enable change to o_puf_en. There is no combinational path from inputs to output.
- Distinct selects (sel0 != sel1): exactly two bits set, so the output has even parity.
- Equal selects (sel0 == sel1): exactly one bit set, so the output has odd parity. This is legal; no error flag is raised.
- Full select range 0..MUX_LENGTH-1 is valid. There is no wrap-around or out-of-range case, because the select width matches.
- Reset released on the same edge as enable is asserted: the first edge after release uses the current inputs.
- Reset mid-operation: output clears asynchronously. Normal decode resumes on the first edge after release.
- No handshake and no state machine.

Decomposition:
- Package puf_soc_pkg:
  - MUX_LENGTH default constant.
  - SEL_W = $clog2(MUX_LENGTH).
  - typedefs for the select type (logic [SEL_W-1:0]) and the enable vector (logic [MUX_LENGTH-1:0]).
- One natural sub-module, puf_soc_onehot_dec: combinational SEL_W-to-MUX_LENGTH one-hot decoder.
  - Instantiated twice, once per mux.
  - Outputs are ORed and registered in the top.
- Include SVA: o_puf_en popcount is in {0,1,2}; o_puf_en is 0 whenever the previous-cycle i_dcod_en was 0.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with all inputs 0 -> o_puf_en = 16'h0000 throughout. Assert rst_n low asynchronously mid-cycle while output is nonzero -> output 0 before the next edge.
- Single decode: en=1, sel0=3, sel1=9 -> after 1 clk o_puf_en = 16'h0208. One cycle earlier it still shows the prior value.
- Equal selects: en=1, sel0=sel1=5 -> o_puf_en = 16'h0020, odd parity.
- Exhaustive sweep: en=1, drive all 256 (sel0,sel1) pairs one per clock -> each result equals onehot(sel0)|onehot(sel1) one cycle later. Exactly 16 results have odd parity (the diagonal); the other 240 have even parity with popcount 2.
- Enable gating: en=1, sel0=0, sel1=15 -> 16'h8001, then deassert en -> 16'h0000 on the next edge regardless of selects. Re-enable -> decode resumes after 1 clk.
- Boundaries: sel0=0, sel1=0 -> 16'h0001; sel0=15, sel1=15 -> 16'h8000.
